// File: rtl/rx_frame_parser.sv
// rx_frame_parser: ASCII '<' [sign] octal fields '>' decoder with shadow/commit outputs and saturating error count
module rx_frame_parser #(
    parameter int NUM_FIELDS = 6,
    parameter int DIGITS = 5,
    parameter logic [NUM_FIELDS-1:0] SIGNED_MASK = 6'b111100,
    parameter int ERR_CNT_W = 8,
    localparam int W = 3 * DIGITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              RX_byte,
    input  logic                    RX_valid,
    output logic [NUM_FIELDS*W-1:0] field_data,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic [ERR_CNT_W-1:0]    err_count,
    output logic                    busy
);
    localparam int FI_W = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
    localparam int DI_W = DIGITS > 1 ? $clog2(DIGITS) : 1;
    typedef enum logic [1:0] {IDLE, SIGN, DIGIT, END} state_t;
    state_t state, state_n;
    logic [FI_W-1:0] field_idx, field_idx_n, next_field;
    logic [DI_W-1:0] digit_idx, digit_idx_n;
    logic neg, neg_n, frame_valid_n, frame_err_n, err, is_oct, last_digit, last_field;
    logic [NUM_FIELDS*W-1:0] shadow, shadow_n, field_data_n;
    logic [ERR_CNT_W-1:0] err_count_n;
    logic [W-1:0] cur, val;
    assign busy = state != IDLE;
    assign is_oct = RX_byte >= "0" && RX_byte <= "7";
    assign last_digit = digit_idx == DI_W'(DIGITS - 1);
    assign last_field = field_idx == FI_W'(NUM_FIELDS - 1);
    assign next_field = field_idx + 1'b1;
    assign cur = shadow[field_idx*W +: W];
    assign val = {cur[W-4:0], RX_byte[2:0]};
    always_comb begin
        state_n = state;
        field_idx_n = field_idx;
        digit_idx_n = digit_idx;
        neg_n = neg;
        shadow_n = shadow;
        field_data_n = field_data;
        frame_valid_n = 1'b0;
        frame_err_n = 1'b0;
        err_count_n = err_count;
        err = 1'b0;
        if (RX_valid) begin
            if (RX_byte == "<") begin
                err = state != IDLE;
                state_n = SIGNED_MASK[0] ? SIGN : DIGIT;
                field_idx_n = '0;
                digit_idx_n = '0;
                neg_n = 1'b0;
            end else begin
                case (state)
                    SIGN: begin
                        err = !(RX_byte == "+" || RX_byte == "-");
                        neg_n = RX_byte == "-";
                        state_n = DIGIT;
                    end
                    DIGIT: begin
                        err = !is_oct;
                        shadow_n[field_idx*W +: W] = last_digit && neg ? ~val : val;
                        digit_idx_n = last_digit ? '0 : digit_idx + 1'b1;
                        if (last_digit) begin
                            field_idx_n = next_field;
                            neg_n = 1'b0;
                            state_n = last_field ? END : (SIGNED_MASK[next_field] ? SIGN : DIGIT);
                        end
                    end
                    END: begin
                        err = RX_byte != ">";
                        field_data_n = shadow;
                        frame_valid_n = 1'b1;
                        state_n = IDLE;
                    end
                    default: ;
                endcase
            end
            if (err) begin
                frame_err_n = 1'b1;
                frame_valid_n = 1'b0;
                field_data_n = field_data;
                shadow_n = shadow;
                err_count_n = &err_count ? err_count : err_count + 1'b1;
                if (RX_byte != "<") state_n = IDLE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            field_idx <= '0;
            digit_idx <= '0;
            neg <= 1'b0;
            shadow <= '0;
            field_data <= '0;
            frame_valid <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            state <= state_n;
            field_idx <= field_idx_n;
            digit_idx <= digit_idx_n;
            neg <= neg_n;
            shadow <= shadow_n;
            field_data <= field_data_n;
            frame_valid <= frame_valid_n;
            frame_err <= frame_err_n;
            err_count <= err_count_n;
        end
    end
endmodule
